seq_restoring_divider: RTL and testbench

// - Iterative unsigned N-bit divider. Drives one Nbit_Sub instance (width N+1) each cycle.
// - Each cycle: shift the partial remainder, trial-subtract the divisor, restore on borrow.
// - Sits directly downstream of Nbit_Sub: consumes its difference (sum) and borrow (c_out).
// - Feeds quotient/remainder to the ALU result mux via a start/done handshake.

---
 rtl/seq_restoring_divider.sv | 128 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock via an N+1 bit trial subtract.
// Optional macro DIVIDER_DBZ_FLAG_EN adds a div_by_zero output and a one-cycle zero-divisor path.

module Nbit_Sub #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  logic carry;

  // a - b computed as a + ~b + c_in; c_out reports borrow (inverted carry)
  assign {carry, sum} = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, c_in};
  assign c_out = ~carry;
endmodule

module seq_restoring_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
`ifdef DIVIDER_DBZ_FLAG_EN
  ,
  output logic         div_by_zero
`endif
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [N:0]    d_reg;
  logic [N-1:0]  q_reg;
  // R[N] is always 0 between iterations (R < D), so only N bits are stored
  logic [N-1:0]  r_reg;
  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          borrow;
  logic [N-1:0]  r_next;
  logic [N-1:0]  q_next;
  logic          unused_diff_msb;

  assign shifted = {r_reg, q_reg[N-1]};

  Nbit_Sub #(.N(N + 1)) u_sub (
    .a     (shifted),
    .b     (d_reg),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (borrow)
  );

  assign unused_diff_msb = diff[N];

  always_comb begin
    r_next = diff[N-1:0];
    if (borrow) begin
      r_next = shifted[N-1:0];
    end
    q_next = {q_reg[N-2:0], ~borrow};
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef DIVIDER_DBZ_FLAG_EN
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else
`endif
            begin
              d_reg <= {1'b0, divisor};
              q_reg <= dividend;
              r_reg <= '0;
              count <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= IDLE;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (N=8): arithmetic reference model plus directed vectors.
// Honours DIVIDER_DBZ_FLAG_EN to match the DUT build.

module tb_seq_restoring_divider;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic         div_by_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIVIDER_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles-remaining counter and plain / and % arithmetic
  int           pend = 0;
  logic         exp_done = 1'b0;
  logic         exp_dbz = 1'b0;
  logic [N-1:0] exp_q = '0;
  logic [N-1:0] exp_r = '0;
  logic [N-1:0] nxt_q = '0;
  logic [N-1:0] nxt_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0; exp_done = 1'b0; exp_dbz = 1'b0; exp_q = '0; exp_r = '0;
    end else begin
      exp_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          exp_done = 1'b1; exp_q = nxt_q; exp_r = nxt_r;
        end
      end else if (start) begin
        nxt_q = (divisor == 0) ? {N{1'b1}} : dividend / divisor;
        nxt_r = (divisor == 0) ? dividend : dividend % divisor;
`ifdef DIVIDER_DBZ_FLAG_EN
        exp_dbz = (divisor == 0);
        if (divisor == 0) begin
          exp_done = 1'b1; exp_q = nxt_q; exp_r = nxt_r;
        end else begin
          pend = N;
        end
`else
        pend = N;
`endif
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(pend > 0));
    check("done", 32'(done), 32'(exp_done));
    check("quotient", 32'(quotient), 32'(exp_q));
    check("remainder", 32'(remainder), 32'(exp_r));
`ifdef DIVIDER_DBZ_FLAG_EN
    check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
`endif
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after the accepting edge; lat = further negedges until done is seen
  task automatic wait_done(input int lat, input logic [N-1:0] eq, input logic [N-1:0] er);
    int k;
    bit seen;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i <= 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    check("done_timeout", 32'(seen), 32'd1);
    check("latency", 32'(k), 32'(lat));
    check("lit_quotient", 32'(quotient), 32'(eq));
    check("lit_remainder", 32'(remainder), 32'(er));
    check("lit_busy_with_done", 32'(busy), 32'd0);
    check("model_quotient", 32'(exp_q), 32'(eq));
    check("model_remainder", 32'(exp_r), 32'(er));
  endtask

  initial begin
    int done_seen;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'd100, 8'd7);
    wait_done(N, 8'd14, 8'd2);

    // Back-to-back start in the done cycle; old results must hold
    issue(8'd200, 8'd13);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    check("b2b_hold_q", 32'(quotient), 32'd14);
    check("b2b_hold_r", 32'(remainder), 32'd2);
    wait_done(N, 8'd15, 8'd5);

    @(negedge clk);
    issue(8'd255, 8'd1);
    wait_done(N, 8'd255, 8'd0);
    issue(8'd5, 8'd9);
    wait_done(N, 8'd0, 8'd5);
    issue(8'd0, 8'd3);
    wait_done(N, 8'd0, 8'd0);

    // start pulsed mid-RUN with new operands is ignored
    @(negedge clk);
    issue(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    issue(8'd50, 8'd3);
    wait_done(N - 4, 8'd14, 8'd2);

    // Async reset after iteration 4 aborts without a done pulse
    @(negedge clk);
    issue(8'd100, 8'd7);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    issue(8'd100, 8'd7);
    wait_done(N, 8'd14, 8'd2);

    @(negedge clk);
    issue(8'd37, 8'd0);
`ifdef DIVIDER_DBZ_FLAG_EN
    wait_done(0, 8'd255, 8'd37);
    check("lit_div_by_zero", 32'(div_by_zero), 32'd1);
    issue(8'd100, 8'd7);
    check("dbz_cleared", 32'(div_by_zero), 32'd0);
    wait_done(N, 8'd14, 8'd2);
`else
    wait_done(N, 8'd255, 8'd37);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
